// File: rtl/gen_senales.sv
// gen_senales: bus-cycle strobe generator for the RTC multiplexed
// address/data interface. Each access is an address subcycle followed by a
// data subcycle of SUB_LEN clocks each. CS, RD, WR, A_D and LE are registered
// chip strobes. enable_cont_16 and enable_cont_32 drive the external index
// counters.
// Optional build macro GEN_SENALES_GAP_EN: inserts a 4-clock idle GAP state
// between back-to-back accesses. Without it, accesses are contiguous.
module gen_senales #(
   parameter int SUB_LEN   = 16,
   parameter int CS_START  = 2,
   parameter int CS_END    = 13,
   parameter int STB_START = 4,
   parameter int STB_END   = 11
) (
   input  logic       reloj,
   input  logic       resetM,
   input  logic [1:0] Control,
   input  logic [3:0] Selec_Mux_DDw,
   input  logic [2:0] Status3bit,
   output logic       enable_cont_16,
   output logic       enable_cont_32,
   output logic       CS,
   output logic       RD,
   output logic       WR,
   output logic       A_D,
   output logic       LE
);

   localparam int TW = $clog2(SUB_LEN);

   localparam logic [TW-1:0] T_ZERO   = '0;
   localparam logic [TW-1:0] T_ONE    = TW'(1);
   localparam logic [TW-1:0] T_LAST   = TW'(SUB_LEN - 1);
   localparam logic [TW-1:0] T_CS_S   = TW'(CS_START);
   localparam logic [TW-1:0] T_CS_E   = TW'(CS_END);
   localparam logic [TW-1:0] T_STB_S  = TW'(STB_START);
   localparam logic [TW-1:0] T_STB_E  = TW'(STB_END);
   localparam logic [TW-1:0] T_GAP_E  = TW'(3);

   localparam logic [1:0] CTL_WR  = 2'b01;
   localparam logic [1:0] CTL_RD  = 2'b10;
   localparam logic [3:0] SEL_END = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_DONE,
      S_GAP
   } state_t;

   state_t        state_q, state_d;
   state_t        next_acc;
   logic [TW-1:0] t_q, t_d;
   logic          rd_mode_q, rd_mode_d;
   logic [2:0]    cnt_q, cnt_d;

   logic cs_q, cs_d;
   logic rd_q, rd_d;
   logic wr_q, wr_d;
   logic a_d_q, a_d_d;
   logic le_q, le_d;
   logic e16_q, e16_d;
   logic e32_q, e32_d;

   logic in_cs_win, in_stb_win;

`ifdef GEN_SENALES_GAP_EN
   assign next_acc = S_GAP;
`else
   assign next_acc = S_ADDR;
`endif

   // Sequencing: state, subcycle timer, access mode and read burst counter
   always_comb begin
      state_d   = state_q;
      t_d       = t_q;
      rd_mode_d = rd_mode_q;
      cnt_d     = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (Control == CTL_WR) begin
               rd_mode_d = 1'b0;
               t_d       = T_ZERO;
               state_d   = (Selec_Mux_DDw == SEL_END) ? S_DONE : S_ADDR;
            end else if (Control == CTL_RD) begin
               rd_mode_d = 1'b1;
               t_d       = T_ZERO;
               cnt_d     = Status3bit;
               state_d   = (Status3bit == 3'd0) ? S_DONE : S_ADDR;
            end
         end
         S_ADDR: begin
            if (t_q == T_LAST) begin
               t_d     = T_ZERO;
               state_d = S_DATA;
            end else begin
               t_d = t_q + T_ONE;
            end
         end
         S_DATA: begin
            if (t_q != T_LAST) begin
               t_d = t_q + T_ONE;
            end else begin
               // Access boundary: the only point where Control is honoured
               t_d = T_ZERO;
               if (!rd_mode_q) begin
                  if (Control != CTL_WR)
                     state_d = S_IDLE;
                  else if (Selec_Mux_DDw == SEL_END)
                     state_d = S_DONE;
                  else
                     state_d = next_acc;
               end else begin
                  cnt_d = cnt_q - 3'd1;
                  if (cnt_q == 3'd1)
                     state_d = S_DONE;
                  else if (Control != CTL_RD)
                     state_d = S_IDLE;
                  else
                     state_d = next_acc;
               end
            end
         end
         S_GAP: begin
            if (t_q == T_GAP_E) begin
               t_d     = T_ZERO;
               state_d = S_ADDR;
            end else begin
               t_d = t_q + T_ONE;
            end
         end
         S_DONE: begin
            // Re-arm only once Control leaves the mode that finished
            if (Control != (rd_mode_q ? CTL_RD : CTL_WR))
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Strobe decode from the upcoming state so every output is a flop
   always_comb begin
      in_cs_win  = (t_d >= T_CS_S) && (t_d <= T_CS_E);
      in_stb_win = (t_d >= T_STB_S) && (t_d <= T_STB_E);
      cs_d  = 1'b1;
      rd_d  = 1'b1;
      wr_d  = 1'b1;
      a_d_d = 1'b1;
      le_d  = 1'b0;
      e16_d = 1'b0;
      e32_d = 1'b0;
      if (state_d == S_ADDR) begin
         a_d_d = 1'b0;
         e32_d = 1'b1;
         cs_d  = ~in_cs_win;
         wr_d  = ~in_stb_win;
      end else if (state_d == S_DATA) begin
         e32_d = 1'b1;
         cs_d  = ~in_cs_win;
         if (rd_mode_d) begin
            rd_d = ~in_stb_win;
            le_d = (t_d == T_STB_E);
         end else begin
            wr_d = ~in_stb_win;
         end
         e16_d = (t_d == T_LAST);
      end
   end

   // State and output registers; reset aborts any access immediately
   always_ff @(posedge reloj or negedge resetM) begin
      if (!resetM) begin
         state_q   <= S_IDLE;
         t_q       <= T_ZERO;
         rd_mode_q <= 1'b0;
         cnt_q     <= 3'd0;
         cs_q      <= 1'b1;
         rd_q      <= 1'b1;
         wr_q      <= 1'b1;
         a_d_q     <= 1'b1;
         le_q      <= 1'b0;
         e16_q     <= 1'b0;
         e32_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         t_q       <= t_d;
         rd_mode_q <= rd_mode_d;
         cnt_q     <= cnt_d;
         cs_q      <= cs_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         a_d_q     <= a_d_d;
         le_q      <= le_d;
         e16_q     <= e16_d;
         e32_q     <= e32_d;
      end
   end

   assign CS             = cs_q;
   assign RD             = rd_q;
   assign WR             = wr_q;
   assign A_D            = a_d_q;
   assign LE             = le_q;
   assign enable_cont_16 = e16_q;
   assign enable_cont_32 = e32_q;

endmodule

// File: tb/tb_gen_senales.sv
// tb_gen_senales: directed sequence with randomized indices and burst
// lengths for gen_senales. Expected strobes come from a per-cycle model of
// an access (position k in 0..31) and the idle pattern.
module tb_gen_senales;

   logic       reloj;
   logic       resetM;
   logic [1:0] Control;
   logic [3:0] Selec_Mux_DDw;
   logic [2:0] Status3bit;
   logic       enable_cont_16, enable_cont_32, CS, RD, WR, A_D, LE;

   int total = 0;
   int bad   = 0;

   // {CS,RD,WR,A_D,LE,enable_cont_16,enable_cont_32}
   localparam logic [6:0] IDLE_V = 7'b1111000;

   gen_senales dut (
      .reloj          (reloj),
      .resetM         (resetM),
      .Control        (Control),
      .Selec_Mux_DDw  (Selec_Mux_DDw),
      .Status3bit     (Status3bit),
      .enable_cont_16 (enable_cont_16),
      .enable_cont_32 (enable_cont_32),
      .CS             (CS),
      .RD             (RD),
      .WR             (WR),
      .A_D            (A_D),
      .LE             (LE)
   );

   initial reloj = 1'b0;
   always #5 reloj = ~reloj;

   // Expected outputs at position k of an access (0..15 address, 16..31 data)
   function automatic logic [6:0] exp_acc(input int k, input bit rdm);
      int   t;
      bit   dat, cs_win, stb;
      logic cs, rd, wr, ad, le, e16;
      dat    = (k >= 16);
      t      = k % 16;
      cs_win = (t >= 2) && (t <= 13);
      stb    = (t >= 4) && (t <= 11);
      cs     = !cs_win;
      ad     = dat;
      wr     = !(stb && (!dat || !rdm));
      rd     = !(stb && dat && rdm);
      le     = dat && rdm && (t == 11);
      e16    = (k == 31);
      return {cs, rd, wr, ad, le, e16, 1'b1};
   endfunction

   task automatic tick();
      @(posedge reloj);
      #1;
   endtask

   task automatic chk(input logic [6:0] exp_v, input string tag, input int k);
      logic [6:0] obs;
      obs = {CS, RD, WR, A_D, LE, enable_cont_16, enable_cont_32};
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp_v);
      end
      total++;
      assert ((!(RD === 1'b0 && WR === 1'b0)) && ((RD === 1'b1 && WR === 1'b1) || CS === 1'b0)) else begin
         bad++;
         $error("FAIL %s_strobe_rule k=%0d observed CS/RD/WR=%b%b%b", tag, k, CS, RD, WR);
      end
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         tick();
         chk(IDLE_V, tag, i);
      end
   endtask

   task automatic access(input bit rdm, input string tag);
      for (int k = 0; k < 32; k++) begin
         tick();
         chk(exp_acc(k, rdm), tag, k);
      end
   endtask

   task automatic between();
`ifdef GEN_SENALES_GAP_EN
      idle(4, "gap");
`endif
   endtask

   // Write sequence: one access per non-F index, then DONE on 4'hF
   task automatic write_seq(input logic [3:0] idx[$], input string tag);
      Control = 2'b01;
      for (int i = 0; i < idx.size(); i++) begin
         Selec_Mux_DDw = idx[i];
         access(1'b0, tag);
         if (i < idx.size() - 1) between();
      end
      Selec_Mux_DDw = 4'hF;
      idle(4, "wr_done");
      Control = 2'b00;
      idle(2, "wr_rearm");
   endtask

   // Read burst of n accesses, then DONE held while Control stays 10
   task automatic read_seq(input int n, input string tag);
      Status3bit = 3'(n);
      Control    = 2'b10;
      for (int i = 0; i < n; i++) begin
         access(1'b1, tag);
         if (i < n - 1) between();
      end
      idle(4, "rd_done");
      Control = 2'b00;
      idle(2, "rd_rearm");
   endtask

   initial begin
      logic [3:0] q[$];
      int n;

      resetM        = 1'b0;
      Control       = 2'b00;
      Selec_Mux_DDw = 4'h0;
      Status3bit    = 3'd0;

      // Reset held 100 ns
      idle(10, "reset");
      resetM = 1'b1;
      idle(3, "idle00");
      Control = 2'b11;
      idle(3, "idle11");
      Control = 2'b00;
      idle(1, "idle00b");

      // Single write at index 3
      q = '{4'h3};
      write_seq(q, "wr_single");

      // Write list 3..B
      q = {};
      for (int i = 3; i <= 11; i++) q.push_back(4'(i));
      write_seq(q, "wr_list");

      // Random write list after re-arm
      q = {};
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) q.push_back(4'($urandom_range(0, 14)));
      write_seq(q, "wr_rand");

      // Write start on 4'hF goes straight to DONE
      Selec_Mux_DDw = 4'hF;
      Control       = 2'b01;
      idle(4, "wr_f_first");
      Control = 2'b00;
      idle(2, "wr_f_rearm");

      // Read bursts
      read_seq(5, "rd5");
      read_seq($urandom_range(1, 7), "rd_rand");
      read_seq(0, "rd0");

      // Control 01 -> 10 mid-access: write finishes, IDLE, then read burst of 2
      Selec_Mux_DDw = 4'h5;
      Control       = 2'b01;
      for (int k = 0; k < 32; k++) begin
         tick();
         chk(exp_acc(k, 1'b0), "wr_switch", k);
         if (k == 9) begin
            Control    = 2'b10;
            Status3bit = 3'd2;
         end
      end
      idle(1, "switch_idle");
      access(1'b1, "rd_after_switch");
      between();
      access(1'b1, "rd_after_switch");
      idle(3, "switch_done");
      Control = 2'b00;
      idle(2, "switch_rearm");

      // Reset at address t=7
      Selec_Mux_DDw = 4'h3;
      Control       = 2'b01;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk(exp_acc(k, 1'b0), "pre_reset", k);
      end
      #1 resetM = 1'b0;
      #1 chk(IDLE_V, "async_reset", 0);
      idle(3, "in_reset");
      resetM = 1'b1;
      access(1'b0, "restart");
      Selec_Mux_DDw = 4'hF;
      idle(3, "restart_done");
      Control = 2'b00;
      idle(2, "end_idle");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
